span_fill_engine: RTL and testbench

- Parametrised successor to the single-mode polygon span filler.
- Walks up to NUM_ROWS raster rows of a pixel mask. For each row it finds the first and last set mask bits.
- For each non-empty row it does a read-modify-write of one row-word of framebuffer memory, using one of four fill modes.
- Empty rows are skipped with no memory traffic. Memory access uses a req/ack handshake instead of fixed wait states.
- Sits between the draw-command decoder (start, origin, mask) and the SRAM arbiter.

---
 rtl/span_fill_engine.sv | 183 ++++++++++++++++++
 tb/tb_span_fill_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/span_fill_engine.sv
// Raster span filler: per row, finds the first/last set mask bits and read-modify-writes
// one framebuffer row-word in one of four fill modes over a req/ack memory port.
module span_fill_engine #(
  parameter int ROW_PIXELS   = 64,
  parameter int NUM_ROWS     = 64,
  parameter int PIXEL_BITS   = 24,
  parameter int ADDR_BITS    = 24,
  parameter int ROW_STRIDE   = 256,
  parameter int LAYER_STRIDE = 65536,
  parameter int NUM_LAYERS   = 2,
  localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int NRW = $clog2(NUM_ROWS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic [1:0]                       fill_mode,
  input  logic [7:0]                       x_origin,
  input  logic [7:0]                       y_origin,
  input  logic [LW-1:0]                    layer,
  input  logic [NRW-1:0]                   num_rows,
  input  logic [PIXEL_BITS-1:0]            color_a,
  input  logic [PIXEL_BITS-1:0]            color_b,
  input  logic [ROW_PIXELS*NUM_ROWS-1:0]   line_mask,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic [ROW_PIXELS*PIXEL_BITS-1:0] mem_wdata,
  input  logic [ROW_PIXELS*PIXEL_BITS-1:0] mem_rdata,
  input  logic                             mem_ack
);

  localparam int PW = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam int RW = ROW_PIXELS * PIXEL_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_RD, S_MERGE, S_WR, S_NEXT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_SPAN, M_MASK, M_CHECKER, M_INVERT
  } mode_e;

  state_e                  state_q, state_d;
  mode_e                   mode_q;
  logic [7:0]              x_q, y_q;
  logic [LW-1:0]           layer_q;
  logic [NRW-1:0]          nrows_q, row_q;
  logic [PIXEL_BITS-1:0]   color_a_q, color_b_q;
  logic [PW-1:0]           first_q, last_q, first_d, last_d;
  logic [ROW_PIXELS-1:0]   mask_q, row_mask;
  logic [RW-1:0]           buf_q, merged;
  logic [PIXEL_BITS-1:0]   px;
  logic                    in_span;
  logic                    row_empty;
  logic [7:0]              y_row;
  logic [ADDR_BITS-1:0]    addr;

  always_comb begin
    row_mask = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (row_q == NRW'(r)) row_mask = line_mask[r*ROW_PIXELS +: ROW_PIXELS];
    end
  end

  always_comb begin
    first_d = '0;
    last_d  = '0;
    for (int unsigned p = ROW_PIXELS; p > 0; p--) begin
      if (row_mask[p-1]) first_d = PW'(p - 1);
    end
    for (int unsigned p = 0; p < ROW_PIXELS; p++) begin
      if (row_mask[p]) last_d = PW'(p);
    end
  end

  assign row_empty = ~|row_mask;

  // Row y is an 8-bit raster coordinate, so origin+row wraps within the layer.
  assign y_row = y_q + 8'(row_q);
  assign addr  = ADDR_BITS'(layer_q) * ADDR_BITS'(LAYER_STRIDE)
               + ADDR_BITS'(y_row) * ADDR_BITS'(ROW_STRIDE)
               + ADDR_BITS'(x_q);

  always_comb begin
    merged  = buf_q;
    px      = '0;
    in_span = 1'b0;
    for (int unsigned p = 0; p < ROW_PIXELS; p++) begin
      px      = buf_q[p*PIXEL_BITS +: PIXEL_BITS];
      in_span = (PW'(p) >= first_q) && (PW'(p) <= last_q);
      unique case (mode_q)
        M_SPAN:    if (in_span) px = color_a_q;
        M_MASK:    if (mask_q[p]) px = color_a_q;
        M_CHECKER: if (in_span) px = (p[0] ^ y_row[0]) ? color_b_q : color_a_q;
        default:   if (in_span) px = ~px;
      endcase
      merged[p*PIXEL_BITS +: PIXEL_BITS] = px;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (num_rows == '0) ? S_DONE : S_SCAN;
      end
      S_SCAN:  state_d = row_empty ? S_NEXT : S_RD;
      S_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr;
        if (mem_ack) state_d = S_MERGE;
      end
      S_MERGE: state_d = S_WR;
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = buf_q;
        if (mem_ack) state_d = S_NEXT;
      end
      S_NEXT:  state_d = (row_q + NRW'(1) == nrows_q) ? S_DONE : S_SCAN;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_SPAN;
      x_q       <= '0;
      y_q       <= '0;
      layer_q   <= '0;
      nrows_q   <= '0;
      row_q     <= '0;
      color_a_q <= '0;
      color_b_q <= '0;
      first_q   <= '0;
      last_q    <= '0;
      mask_q    <= '0;
      buf_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode_e'(fill_mode);
            x_q       <= x_origin;
            y_q       <= y_origin;
            layer_q   <= layer;
            nrows_q   <= num_rows;
            color_a_q <= color_a;
            color_b_q <= color_b;
            row_q     <= '0;
          end
        end
        S_SCAN: begin
          first_q <= first_d;
          last_q  <= last_d;
          mask_q  <= row_mask;
        end
        S_RD:    if (mem_ack) buf_q <= mem_rdata;
        S_MERGE: buf_q <= merged;
        S_NEXT:  row_q <= row_q + NRW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_span_fill_engine.sv
// Directed bench for span_fill_engine: memory model with programmable ack delay,
// transaction log, handshake-hold monitor and hand-computed row images.
module tb_span_fill_engine;

  localparam int RP = 64;
  localparam int NR = 64;
  localparam int PB = 24;
  localparam int RWB = RP * PB;

  logic             clk = 1'b0;
  logic             rst, start, busy, done;
  logic [1:0]       fill_mode;
  logic [7:0]       x_origin, y_origin;
  logic [0:0]       layer;
  logic [6:0]       num_rows;
  logic [PB-1:0]    color_a, color_b;
  logic [RP*NR-1:0] line_mask;
  logic             mem_req, mem_we, mem_ack;
  logic [23:0]      mem_addr;
  logic [RWB-1:0]   mem_wdata, mem_rdata;

  logic [PB-1:0]    rd_pix;
  int               ack_delay;
  int               wait_cnt;
  int               n_vec = 0;
  int               n_err = 0;
  int               done_cnt = 0;

  typedef struct {
    logic           we;
    logic [23:0]    addr;
    logic [RWB-1:0] data;
  } acc_t;
  acc_t acc_q[$];

  logic             pend = 1'b0;
  logic             ack_prev = 1'b0;
  logic [23:0]      p_addr;
  logic             p_we;
  logic [RWB-1:0]   p_wdata;
  logic [RWB-1:0]   exp_row;

  always #5 clk = ~clk;

  span_fill_engine #(
    .ROW_PIXELS(RP), .NUM_ROWS(NR), .PIXEL_BITS(PB), .ADDR_BITS(24),
    .ROW_STRIDE(256), .LAYER_STRIDE(65536), .NUM_LAYERS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fill_mode(fill_mode), .x_origin(x_origin), .y_origin(y_origin),
    .layer(layer), .num_rows(num_rows), .color_a(color_a), .color_b(color_b),
    .line_mask(line_mask), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  assign mem_rdata = {RP{rd_pix}};
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: request fields must hold until ack, and req must drop after ack.
  always @(negedge clk) begin
    if (pend && !rst) begin
      check_eq("hold_req",   mem_req, 1);
      check_eq("hold_we",    mem_we, p_we);
      check_eq("hold_addr",  mem_addr, p_addr);
      check_eq("hold_wdata", mem_wdata == p_wdata, 1);
    end
    if (ack_prev && !rst) check_eq("req_drop_after_ack", mem_req, 0);
    if (mem_req && mem_ack) acc_q.push_back('{mem_we, mem_addr, mem_wdata});
    if (done) done_cnt++;
    pend     = mem_req && !mem_ack;
    ack_prev = mem_req && mem_ack;
    p_addr   = mem_addr;
    p_we     = mem_we;
    p_wdata  = mem_wdata;
  end

  task automatic clear_log();
    acc_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_op(input string tag, input int exp_cyc, input int poke_at);
    int k;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge clk);
      #1;
      k++;
      if (done) seen = 1'b1;
      @(negedge clk);
      start = (k == poke_at);
      if (k == poke_at) begin
        num_rows  = 7'd1;
        fill_mode = 2'd3;
        color_a   = 24'h123123;
        x_origin  = 8'h00;
      end
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_latency"}, k + 1, exp_cyc);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_count"}, done_cnt, 1);
    check_eq({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_rd(input string tag, input int idx, input logic [23:0] a);
    check_eq({tag, "_present"}, idx < acc_q.size(), 1);
    if (idx < acc_q.size()) begin
      check_eq({tag, "_we"}, acc_q[idx].we, 0);
      check_eq({tag, "_addr"}, acc_q[idx].addr, a);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [23:0] a,
                          input logic [RWB-1:0] exp);
    check_eq({tag, "_present"}, idx < acc_q.size(), 1);
    if (idx < acc_q.size()) begin
      check_eq({tag, "_we"}, acc_q[idx].we, 1);
      check_eq({tag, "_addr"}, acc_q[idx].addr, a);
      for (int p = 0; p < RP; p++)
        check_eq($sformatf("%s_px%0d", tag, p), acc_q[idx].data[p*PB +: PB], exp[p*PB +: PB]);
    end
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                       input logic l, input logic [6:0] n, input logic [23:0] ca,
                       input logic [23:0] cb, input logic [23:0] rp);
    fill_mode = m; x_origin = x; y_origin = y; layer = l; num_rows = n;
    color_a = ca; color_b = cb; rd_pix = rp;
    line_mask = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; ack_delay = 0;
    setup(2'd0, 8'd0, 8'd0, 1'b0, 7'd0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata == '0, 1);
    rst = 1'b0;

    // SPAN, single row, pixels 3..10
    setup(2'd0, 8'd16, 8'd4, 1'b0, 7'd1, 24'hFF0000, 24'h0, 24'h000000);
    line_mask[63:0] = 64'h0000_0000_0000_07F8;
    clear_log();
    run_op("span", 7, 0);
    check_eq("span_nacc", acc_q.size(), 2);
    check_rd("span_rd", 0, 24'h000410);
    exp_row = {RP{24'h000000}};
    for (int p = 3; p <= 10; p++) exp_row[p*PB +: PB] = 24'hFF0000;
    check_wr("span_wr", 1, 24'h000410, exp_row);

    // MASK, only the two end pixels are set
    setup(2'd1, 8'd0, 8'd0, 1'b0, 7'd1, 24'h00FF00, 24'h0, 24'h123456);
    line_mask[63:0] = 64'h8000_0000_0000_0001;
    clear_log();
    run_op("mask", 7, 0);
    check_eq("mask_nacc", acc_q.size(), 2);
    exp_row = {RP{24'h123456}};
    exp_row[0*PB +: PB]  = 24'h00FF00;
    exp_row[63*PB +: PB] = 24'h00FF00;
    check_wr("mask_wr", 1, 24'h000000, exp_row);

    // Three rows with an empty middle row
    setup(2'd0, 8'd0, 8'd8, 1'b0, 7'd3, 24'h00FF00, 24'h0, 24'h222222);
    line_mask[63:0]    = 64'h0000_0000_0000_00F0;
    line_mask[128 +: 64] = 64'h0000_0000_0000_0001;
    clear_log();
    run_op("skip", 14, 0);
    check_eq("skip_nacc", acc_q.size(), 4);
    check_rd("skip_rd0", 0, 24'h000800);
    exp_row = {RP{24'h222222}};
    for (int p = 4; p <= 7; p++) exp_row[p*PB +: PB] = 24'h00FF00;
    check_wr("skip_wr0", 1, 24'h000800, exp_row);
    check_rd("skip_rd2", 2, 24'h000A00);
    exp_row = {RP{24'h222222}};
    exp_row[0 +: PB] = 24'h00FF00;
    check_wr("skip_wr2", 3, 24'h000A00, exp_row);

    // CHECKER across a span with interior holes in the mask
    setup(2'd2, 8'h40, 8'd1, 1'b0, 7'd1, 24'hAAAAAA, 24'h555555, 24'h111111);
    line_mask[63:0] = 64'h0000_0000_0000_0009;
    clear_log();
    run_op("chk", 7, 0);
    exp_row = {RP{24'h111111}};
    exp_row[0*PB +: PB] = 24'h555555;
    exp_row[1*PB +: PB] = 24'hAAAAAA;
    exp_row[2*PB +: PB] = 24'h555555;
    exp_row[3*PB +: PB] = 24'hAAAAAA;
    check_rd("chk_rd", 0, 24'h000140);
    check_wr("chk_wr", 1, 24'h000140, exp_row);

    // INVERT over the same span
    setup(2'd3, 8'h40, 8'd1, 1'b0, 7'd1, 24'hAAAAAA, 24'h555555, 24'h0F0F0F);
    line_mask[63:0] = 64'h0000_0000_0000_0009;
    clear_log();
    run_op("inv", 7, 0);
    exp_row = {RP{24'h0F0F0F}};
    for (int p = 0; p <= 3; p++) exp_row[p*PB +: PB] = 24'hF0F0F0;
    check_wr("inv_wr", 1, 24'h000140, exp_row);

    // Delayed ack, layer 1, y wrap, start pulse with altered inputs mid-operation
    ack_delay = 3;
    setup(2'd0, 8'h20, 8'd255, 1'b1, 7'd2, 24'h0000FF, 24'h0, 24'h333333);
    line_mask[63:0]   = 64'h0000_0000_0000_0001;
    line_mask[64 +: 64] = 64'h0000_0000_0000_0002;
    clear_log();
    run_op("dly", 24, 5);
    check_eq("dly_nacc", acc_q.size(), 4);
    check_rd("dly_rd0", 0, 24'h01FF20);
    exp_row = {RP{24'h333333}};
    exp_row[0 +: PB] = 24'h0000FF;
    check_wr("dly_wr0", 1, 24'h01FF20, exp_row);
    check_rd("dly_rd1", 2, 24'h010020);
    exp_row = {RP{24'h333333}};
    exp_row[1*PB +: PB] = 24'h0000FF;
    check_wr("dly_wr1", 3, 24'h010020, exp_row);

    // num_rows == 0
    ack_delay = 0;
    setup(2'd0, 8'd0, 8'd0, 1'b0, 7'd0, 24'hFFFFFF, 24'h0, 24'h0);
    line_mask[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    clear_log();
    run_op("zero", 2, 0);
    check_eq("zero_nacc", acc_q.size(), 0);

    // Reset while the write is pending
    ack_delay = 3;
    setup(2'd0, 8'd0, 8'd2, 1'b0, 7'd1, 24'hABCDEF, 24'h0, 24'h0);
    line_mask[63:0] = 64'h0000_0000_0000_00FF;
    clear_log();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mem_req && mem_we) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("rstwr_reached_wr", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstwr_req", mem_req, 0);
    check_eq("rstwr_busy", busy, 0);
    check_eq("rstwr_done", done, 0);
    check_eq("rstwr_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rstwr_no_done", done_cnt, 0);
    check_eq("rstwr_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
